// File: rtl/axi_buf_pkg.sv
// Shared widths, burst encodings and beat helper for the AXI address-channel FIFO buffer.
package axi_buf_pkg;

  localparam int unsigned AX_FIXED_BITS = 29;
  localparam int unsigned ATOP_BITS     = 6;
  localparam int unsigned LEN_BITS      = 8;
  // Bit offset of len inside a packed entry, above qos(4) cache(4) lock(1) burst(2) size(3).
  localparam int unsigned LEN_LSB       = 14;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_e;

  function automatic logic [LEN_BITS:0] beats_of(input logic [LEN_BITS-1:0] len);
    return {1'b0, len} + (LEN_BITS + 1)'(1);
  endfunction

endpackage

// File: rtl/axi_buf_fifo.sv
// Circular-buffer FIFO with optional fall-through bypass, synchronous flush and occupancy.
module axi_buf_fifo
  import axi_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FALL_THROUGH = 0,
  localparam int unsigned UsageW      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i,
  output logic [UsageW-1:0]     usage_o,
  output logic                  push_o,
  output logic                  pop_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [UsageW-1:0]     usage_q, usage_d;
  logic                  empty, full, blocked, bypass;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign blocked     = rst_i | flush_i;
  assign empty       = (usage_q == '0);
  assign full        = (usage_q == UsageW'(DEPTH));
  assign bypass      = (FALL_THROUGH != 0) & empty & in_valid_i;
  assign in_ready_o  = ~full & ~blocked;
  assign out_valid_o = (~empty | bypass) & ~blocked;
  assign out_data_o  = bypass ? in_data_i : mem_q[rd_ptr_q];
  // A bypassed request is consumed directly and never occupies an entry.
  assign push_o      = in_valid_i & in_ready_o & ~(bypass & out_ready_i);
  assign pop_o       = out_valid_o & out_ready_i & ~empty;
  assign usage_o     = usage_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (push_o) wr_ptr_d = ptr_next(wr_ptr_q);
    if (pop_o)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({push_o, pop_o})
      2'b10:   usage_d = usage_q + UsageW'(1);
      2'b01:   usage_d = usage_q - UsageW'(1);
      default: usage_d = usage_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_o) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/axi_ax_fifo_buffer.sv
// AXI AW/AR address-channel buffer: packs request fields into a FIFO and tracks buffered beats.
module axi_ax_fifo_buffer
  import axi_buf_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned USER_WIDTH   = 1,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FALL_THROUGH = 0,
  parameter int unsigned HAS_ATOP     = 0,
  localparam int unsigned UsageW      = $clog2(DEPTH + 1),
  localparam int unsigned BeatsW      = $clog2(DEPTH * 256 + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  slave_valid_i,
  input  logic [ADDR_WIDTH-1:0] slave_addr_i,
  input  logic [2:0]            slave_prot_i,
  input  logic [3:0]            slave_region_i,
  input  logic [7:0]            slave_len_i,
  input  logic [2:0]            slave_size_i,
  input  logic [1:0]            slave_burst_i,
  input  logic                  slave_lock_i,
  input  logic [3:0]            slave_cache_i,
  input  logic [3:0]            slave_qos_i,
  input  logic [5:0]            slave_atop_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [ADDR_WIDTH-1:0] master_addr_o,
  output logic [2:0]            master_prot_o,
  output logic [3:0]            master_region_o,
  output logic [7:0]            master_len_o,
  output logic [2:0]            master_size_o,
  output logic [1:0]            master_burst_o,
  output logic                  master_lock_o,
  output logic [3:0]            master_cache_o,
  output logic [3:0]            master_qos_o,
  output logic [5:0]            master_atop_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  input  logic                  master_ready_i,
  output logic [UsageW-1:0]     usage_o,
  output logic [BeatsW-1:0]     beats_o
);

  localparam int unsigned BaseW = AX_FIXED_BITS + ADDR_WIDTH + USER_WIDTH + ID_WIDTH;
  localparam int unsigned DataW = BaseW + ((HAS_ATOP != 0) ? ATOP_BITS : 0);

  logic [BaseW-1:0]  in_base;
  logic [DataW-1:0]  in_data, head_data, out_data;
  logic              push, pop;
  logic [BeatsW-1:0] beats_q, beats_d;

  assign in_base = {slave_id_i, slave_user_i, slave_addr_i, slave_prot_i, slave_region_i,
                    slave_len_i, slave_size_i, slave_burst_i, slave_lock_i, slave_cache_i,
                    slave_qos_i};

  if (HAS_ATOP != 0) begin : g_atop
    assign in_data       = {slave_atop_i, in_base};
    assign master_atop_o = out_data[DataW-1 -: ATOP_BITS];
  end else begin : g_no_atop
    logic unused_atop;
    assign in_data       = in_base;
    assign unused_atop   = ^slave_atop_i;
    assign master_atop_o = '0;
  end

  axi_buf_fifo #(
    .DATA_WIDTH  (DataW),
    .DEPTH       (DEPTH),
    .FALL_THROUGH(FALL_THROUGH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (slave_valid_i),
    .in_data_i  (in_data),
    .in_ready_o (slave_ready_o),
    .out_valid_o(master_valid_o),
    .out_data_o (head_data),
    .out_ready_i(master_ready_i),
    .usage_o    (usage_o),
    .push_o     (push),
    .pop_o      (pop)
  );

  // Idle outputs are forced to zero so downstream never sees stale RAM contents.
  assign out_data = master_valid_o ? head_data : '0;
  assign {master_id_o, master_user_o, master_addr_o, master_prot_o, master_region_o,
          master_len_o, master_size_o, master_burst_o, master_lock_o, master_cache_o,
          master_qos_o} = out_data[BaseW-1:0];

  always_comb begin
    beats_d = beats_q;
    if (push) beats_d = beats_d + BeatsW'(beats_of(slave_len_i));
    if (pop)  beats_d = beats_d - BeatsW'(beats_of(head_data[LEN_LSB +: LEN_BITS]));
    if (flush_i) beats_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) beats_q <= '0;
    else       beats_q <= beats_d;
  end

  assign beats_o = beats_q;

endmodule

// File: tb/tb_axi_ax_fifo_buffer.sv
// Randomized scoreboard bench: two buffer configurations checked against a queue-based model.
module tb_axi_ax_fifo_buffer;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned UserW = 2;

  typedef struct packed {
    logic [5:0]       atop;
    logic [IdW-1:0]   id;
    logic [UserW-1:0] user;
    logic [AddrW-1:0] addr;
    logic [2:0]       prot;
    logic [3:0]       region;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [3:0]       qos;
  } ax_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input int inst, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL inst%0d %s: got %h expected %h", inst, name, act, exp);
    end
  endtask

  function automatic ax_t rand_ax(input logic [7:0] len);
    ax_t a;
    a.atop   = 6'($urandom());
    a.id     = IdW'($urandom());
    a.user   = UserW'($urandom());
    a.addr   = AddrW'($urandom());
    a.prot   = 3'($urandom());
    a.region = 4'($urandom());
    a.len    = len;
    a.size   = 3'($urandom());
    a.burst  = 2'($urandom());
    a.lock   = 1'($urandom());
    a.cache  = 4'($urandom());
    a.qos    = 4'($urandom());
    return a;
  endfunction

  // Instance 0: DEPTH=4, registered, with ATOP. Instance 1: DEPTH=3, fall-through, no ATOP.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned D  = (g == 0) ? 4 : 3;
    localparam int unsigned Ft = (g == 0) ? 0 : 1;
    localparam int unsigned Ha = (g == 0) ? 1 : 0;
    localparam int unsigned UW = $clog2(D + 1);
    localparam int unsigned BW = $clog2(D * 256 + 1);

    logic          rst, flush, valid, mready, sready, mvalid;
    ax_t           in_ax, out_ax;
    logic [UW-1:0] usage;
    logic [BW-1:0] beats;
    logic          done = 1'b0;
    ax_t           mq[$];

    axi_ax_fifo_buffer #(
      .ID_WIDTH    (IdW),
      .ADDR_WIDTH  (AddrW),
      .USER_WIDTH  (UserW),
      .DEPTH       (D),
      .FALL_THROUGH(Ft),
      .HAS_ATOP    (Ha)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .slave_valid_i  (valid),
      .slave_addr_i   (in_ax.addr),
      .slave_prot_i   (in_ax.prot),
      .slave_region_i (in_ax.region),
      .slave_len_i    (in_ax.len),
      .slave_size_i   (in_ax.size),
      .slave_burst_i  (in_ax.burst),
      .slave_lock_i   (in_ax.lock),
      .slave_cache_i  (in_ax.cache),
      .slave_qos_i    (in_ax.qos),
      .slave_atop_i   (in_ax.atop),
      .slave_id_i     (in_ax.id),
      .slave_user_i   (in_ax.user),
      .slave_ready_o  (sready),
      .master_valid_o (mvalid),
      .master_addr_o  (out_ax.addr),
      .master_prot_o  (out_ax.prot),
      .master_region_o(out_ax.region),
      .master_len_o   (out_ax.len),
      .master_size_o  (out_ax.size),
      .master_burst_o (out_ax.burst),
      .master_lock_o  (out_ax.lock),
      .master_cache_o (out_ax.cache),
      .master_qos_o   (out_ax.qos),
      .master_atop_o  (out_ax.atop),
      .master_id_o    (out_ax.id),
      .master_user_o  (out_ax.user),
      .master_ready_i (mready),
      .usage_o        (usage),
      .beats_o        (beats)
    );

    // Monitor: compare the DUT against the model, then advance the model for this cycle.
    always @(negedge clk) begin : mon
      ax_t         exp_ax;
      int unsigned sum;
      logic        empty, bypass, exp_ready, exp_mvalid, do_pop, do_push;
      empty      = (mq.size() == 0);
      bypass     = (Ft != 0) && empty && valid;
      exp_ready  = (mq.size() < D) && !flush && !rst;
      exp_mvalid = (!empty || bypass) && !flush && !rst;
      exp_ax     = '0;
      if (exp_mvalid) exp_ax = empty ? in_ax : mq[0];
      if (Ha == 0) exp_ax.atop = '0;
      sum = 0;
      foreach (mq[i]) sum += int'(mq[i].len) + 1;
      check(g, "slave_ready", 128'(sready), 128'(exp_ready));
      check(g, "master_valid", 128'(mvalid), 128'(exp_mvalid));
      check(g, "master_fields", 128'(out_ax), 128'(exp_ax));
      check(g, "usage", 128'(usage), 128'(mq.size()));
      check(g, "beats", 128'(beats), 128'(sum));
      if (rst || flush) begin
        mq.delete();
      end else begin
        do_pop  = exp_mvalid && mready && !empty;
        do_push = valid && exp_ready && !(bypass && mready);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(in_ax);
      end
    end

    task automatic cyc(input logic v, input logic r, input logic f, input logic [7:0] len,
                       input int atop);
      valid  = v;
      mready = r;
      flush  = f;
      in_ax  = rand_ax(len);
      if (atop >= 0) in_ax.atop = 6'(atop);
      @(posedge clk);
      #1;
    endtask

    initial begin
      rst    = 1'b1;
      flush  = 1'b0;
      valid  = 1'b0;
      mready = 1'b0;
      in_ax  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // Fill with len 0,3,7,15 and hold one more request against a full buffer.
      cyc(1'b1, 1'b0, 1'b0, 8'd0, 'h21);
      cyc(1'b1, 1'b0, 1'b0, 8'd3, -1);
      cyc(1'b1, 1'b0, 1'b0, 8'd7, -1);
      cyc(1'b1, 1'b0, 1'b0, 8'd15, -1);
      cyc(1'b1, 1'b0, 1'b0, 8'd1, -1);
      repeat (D + 1) cyc(1'b0, 1'b1, 1'b0, 8'd0, -1);
      // Push into an empty buffer with ready high (bypass on the fall-through instance).
      cyc(1'b1, 1'b1, 1'b0, 8'd5, -1);
      cyc(1'b0, 1'b1, 1'b0, 8'd0, -1);
      // Simultaneous push and pop at usage 2.
      cyc(1'b1, 1'b0, 1'b0, 8'd3, -1);
      cyc(1'b1, 1'b0, 1'b0, 8'd2, -1);
      cyc(1'b1, 1'b1, 1'b0, 8'd9, -1);
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'd0, -1);
      // Flush at usage 3 while a request is pending.
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 8'($urandom()), -1);
      cyc(1'b1, 1'b0, 1'b1, 8'd4, -1);
      cyc(1'b0, 1'b0, 1'b0, 8'd0, -1);
      // Reset while holding entries.
      cyc(1'b1, 1'b0, 1'b0, 8'd200, -1);
      cyc(1'b1, 1'b0, 1'b0, 8'd255, -1);
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 8'd3, -1);
      rst = 1'b0;
      for (int i = 0; i < 600; i++) begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0,
            ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 'h21 : -1);
      end
      cyc(1'b0, 1'b0, 1'b0, 8'd0, -1);
      done = 1'b1;
    end
  end

  initial begin : finish_blk
    int waited;
    waited = 0;
    while (!(g_inst[0].done && g_inst[1].done) && waited < 5000) begin
      @(posedge clk);
      waited++;
    end
    if (waited >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: stimulus done flags %b%b, required 11",
               g_inst[0].done, g_inst[1].done);
    end
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
